// File: rtl/mm_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : mm_wb_buffer
//  Purpose  : Result write-back buffer for the matrix unit. Captures up to 16
//             result rows of 16 bytes from the MXU and packs them into masked
//             128-bit RAM line writes starting at an arbitrary byte address.
//             Unaligned tiles straddle line boundaries: each line combines the
//             head of row k with the tail of row k-1.
//  Ports    :
//    clk, rst                    clock, synchronous active-high reset
//    lsu_mm_wb_ctrl_*            tile descriptor (row_len, col_len,
//                                start_addr) with vld/rdy handshake
//    mxu_mm_wb_res_vld/data      one result row per cycle, no backpressure
//    lsu_mm_wb_ram_write_*       line write request (vld/gnt, addr, data,
//                                byte mask) to the shared RAM port
//    lsu_mm_wb_done              one-cycle pulse when the tile is written
//  Revision : 1.0  initial release
// ============================================================================
module mm_wb_buffer (
  input  logic         clk,
  input  logic         rst,
  input  logic         lsu_mm_wb_ctrl_vld,
  output logic         lsu_mm_wb_ctrl_rdy,
  input  logic [3:0]   lsu_mm_wb_ctrl_row_len,
  input  logic [3:0]   lsu_mm_wb_ctrl_col_len,
  input  logic [11:0]  lsu_mm_wb_ctrl_start_addr,
  input  logic         mxu_mm_wb_res_vld,
  input  logic [127:0] mxu_mm_wb_res_data,
  output logic         lsu_mm_wb_ram_write_vld,
  input  logic         lsu_mm_wb_ram_write_gnt,
  output logic [7:0]   lsu_mm_wb_ram_write_addr,
  output logic [127:0] lsu_mm_wb_ram_write_data,
  output logic [15:0]  lsu_mm_wb_ram_write_mask,
  output logic         lsu_mm_wb_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     row_len_q, row_len_d;
  logic [3:0]     col_len_q, col_len_d;
  logic [11:0]    start_q, start_d;
  logic [4:0]     rcv_q, rcv_d;      // rows captured so far
  logic [4:0]     lin_q, lin_d;      // index of the line currently offered
  logic           rdy_q, rdy_d;
  logic           vld_q, vld_d;
  logic           done_q, done_d;
  logic [7:0]     addr_q, addr_d;
  logic [127:0]   data_q, data_d;
  logic [15:0]    mask_q, mask_d;

  logic [127:0]   store_q [16];

  // Byte mask of line k. The column span of a row, shifted by the start
  // offset, covers 32 byte positions: the low half lands in line k (head
  // of row k), the high half spills into line k+1 (tail of row k).
  function automatic logic [15:0] line_mask(input logic [4:0] k,
                                            input logic [4:0] rows,
                                            input logic [3:0] off,
                                            input logic [3:0] col);
    logic [31:0] span;
    logic [15:0] head;
    logic [15:0] tail;
    span = {16'h0000, 16'hFFFF >> (4'd15 - col)} << off;
    head = (k < rows)  ? span[15:0]  : 16'h0000;
    tail = (k != 5'd0) ? span[31:16] : 16'h0000;
    return head | tail;
  endfunction

  // Current-line view, used to decide advancement this cycle
  logic [4:0] rows_q;
  logic [3:0] off_q;
  logic [4:0] nl_q;
  logic       row_acc;
  logic       cur_ready;
  logic       adv;

  // Next-line view, used to compute the registered outputs
  logic [4:0]   rows_n;
  logic [3:0]   off_n;
  logic         ready_n;
  logic         busy_n;
  logic [15:0]  mask_n;
  logic [127:0] row_h;
  logic [127:0] row_t;
  logic [255:0] head_sh;
  logic [255:0] tail_sh;
  logic [127:0] line_n;

  always_comb begin
    rows_q    = {1'b0, row_len_q} + 5'd1;
    off_q     = start_q[3:0];
    nl_q      = rows_q + {4'd0, (off_q != 4'd0)};
    row_acc   = (state_q == ST_BUSY) && mxu_mm_wb_res_vld &&
                (rcv_q <= {1'b0, row_len_q});
    // The final tail-only line needs no new row: its source row was
    // captured before the preceding line could be granted.
    cur_ready = (rcv_q > lin_q) || ((lin_q == rows_q) && (off_q != 4'd0));
    // A ready line with an empty mask is dropped without a request.
    adv       = (vld_q && lsu_mm_wb_ram_write_gnt) ||
                (cur_ready && (mask_q == 16'h0000));

    state_d   = state_q;
    row_len_d = row_len_q;
    col_len_d = col_len_q;
    start_d   = start_q;
    rcv_d     = rcv_q;
    lin_d     = lin_q;

    case (state_q)
      ST_IDLE: begin
        if (lsu_mm_wb_ctrl_vld) begin
          row_len_d = lsu_mm_wb_ctrl_row_len;
          col_len_d = lsu_mm_wb_ctrl_col_len;
          start_d   = lsu_mm_wb_ctrl_start_addr;
          rcv_d     = 5'd0;
          lin_d     = 5'd0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        rcv_d = rcv_q + {4'd0, row_acc};
        if (adv) begin
          lin_d = lin_q + 5'd1;
          if (lin_q == nl_q - 5'd1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are built from the next-state view.
    // A row being captured this very cycle is forwarded from the input so
    // its line can be offered on the following cycle.
    rows_n  = {1'b0, row_len_d} + 5'd1;
    off_n   = start_d[3:0];
    busy_n  = (state_d == ST_BUSY);
    ready_n = (rcv_d > lin_d) || ((lin_d == rows_n) && (off_n != 4'd0));
    mask_n  = line_mask(lin_d, rows_n, off_n, col_len_d);

    row_h = (row_acc && (rcv_q == lin_d)) ?
            mxu_mm_wb_res_data : store_q[lin_d[3:0]];
    row_t = (row_acc && (rcv_q == lin_d - 5'd1)) ?
            mxu_mm_wb_res_data : store_q[lin_d[3:0] - 4'd1];

    // Head bytes shift up by the offset within line k; tail bytes are
    // what shifts out of the top of row k-1.
    head_sh = {128'h0, row_h} << {off_n, 3'b000};
    tail_sh = {128'h0, row_t} << {off_n, 3'b000};
    line_n  = head_sh[127:0] | tail_sh[255:128];

    vld_d  = busy_n && ready_n && (mask_n != 16'h0000);
    mask_d = busy_n ? mask_n : 16'h0000;
    addr_d = busy_n ? (start_d[11:4] + {3'b000, lin_d}) : 8'h00;
    data_d = 128'h0;
    for (int i = 0; i < 16; i++) begin
      data_d[i*8 +: 8] = (busy_n && mask_n[i]) ? line_n[i*8 +: 8] : 8'h00;
    end
    rdy_d  = (state_d == ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_len_q <= 4'd0;
      col_len_q <= 4'd0;
      start_q   <= 12'h000;
      rcv_q     <= 5'd0;
      lin_q     <= 5'd0;
      rdy_q     <= 1'b1;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= 8'h00;
      data_q    <= 128'h0;
      mask_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      row_len_q <= row_len_d;
      col_len_q <= col_len_d;
      start_q   <= start_d;
      rcv_q     <= rcv_d;
      lin_q     <= lin_d;
      rdy_q     <= rdy_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
    end
  end

  // Row storage carries no reset; the row counter defines which entries
  // are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && row_acc) begin
      store_q[rcv_q[3:0]] <= mxu_mm_wb_res_data;
    end
  end

  assign lsu_mm_wb_ctrl_rdy       = rdy_q;
  assign lsu_mm_wb_ram_write_vld  = vld_q;
  assign lsu_mm_wb_ram_write_addr = addr_q;
  assign lsu_mm_wb_ram_write_data = data_q;
  assign lsu_mm_wb_ram_write_mask = mask_q;
  assign lsu_mm_wb_done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mm_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mm_wb_buffer
//  Purpose  : Self-checking bench for mm_wb_buffer. Expected line writes are
//             derived by scattering every tile byte to its absolute address
//             and grouping by line; a monitor compares each granted write.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mm_wb_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         ctrl_vld;
  logic         ctrl_rdy;
  logic [3:0]   ctrl_row_len;
  logic [3:0]   ctrl_col_len;
  logic [11:0]  ctrl_start;
  logic         res_vld;
  logic [127:0] res_data;
  logic         wr_vld;
  logic         wr_gnt;
  logic [7:0]   wr_addr;
  logic [127:0] wr_data;
  logic [15:0]  wr_mask;
  logic         done;

  always #5 clk = ~clk;

  mm_wb_buffer dut (
    .clk                       (clk),
    .rst                       (rst),
    .lsu_mm_wb_ctrl_vld        (ctrl_vld),
    .lsu_mm_wb_ctrl_rdy        (ctrl_rdy),
    .lsu_mm_wb_ctrl_row_len    (ctrl_row_len),
    .lsu_mm_wb_ctrl_col_len    (ctrl_col_len),
    .lsu_mm_wb_ctrl_start_addr (ctrl_start),
    .mxu_mm_wb_res_vld         (res_vld),
    .mxu_mm_wb_res_data        (res_data),
    .lsu_mm_wb_ram_write_vld   (wr_vld),
    .lsu_mm_wb_ram_write_gnt   (wr_gnt),
    .lsu_mm_wb_ram_write_addr  (wr_addr),
    .lsu_mm_wb_ram_write_data  (wr_data),
    .lsu_mm_wb_ram_write_mask  (wr_mask),
    .lsu_mm_wb_done            (done)
  );

  typedef struct packed {
    logic [7:0]   addr;
    logic [127:0] data;
    logic [15:0]  mask;
  } wr_t;

  wr_t exp_q[$];
  wr_t log_q[$];
  int  logc_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  function automatic logic [127:0] row_pat(input logic [7:0] seed, input int r);
    logic [127:0] d;
    for (int j = 0; j < 16; j++) d[j*8 +: 8] = seed + 8'(r*16 + j);
    return d;
  endfunction

  // Scatter each tile byte to start + 16*r + j, then group by RAM line.
  task automatic build_expected(input int sa, input int rl, input int cl,
                                input logic [7:0] seed);
    int first_ln;
    int last_ln;
    first_ln = sa >> 4;
    last_ln  = (sa + rl*16 + cl) >> 4;
    for (int ln = first_ln; ln <= last_ln; ln++) begin
      wr_t w;
      w = '0;
      w.addr = 8'(ln);
      for (int r = 0; r <= rl; r++) begin
        for (int j = 0; j <= cl; j++) begin
          int a;
          a = sa + r*16 + j;
          if ((a >> 4) == ln) begin
            w.mask[a[3:0]] = 1'b1;
            w.data[a[3:0]*8 +: 8] = seed + 8'(r*16 + j);
          end
        end
      end
      if (w.mask != 16'h0) exp_q.push_back(w);
    end
  endtask

  // Monitor: compares every granted write and checks hold stability
  logic p_hold = 1'b0;
  wr_t  p_w;
  always @(negedge clk) begin
    wr_t cur;
    wr_t e;
    cur = '{addr: wr_addr, data: wr_data, mask: wr_mask};
    if (rst) begin
      p_hold = 1'b0;
    end else begin
      if (p_hold) begin
        chk("hold_vld", 128'(wr_vld), 128'(1));
        chk("hold_addr", 128'(cur.addr), 128'(p_w.addr));
        chk("hold_data", cur.data, p_w.data);
        chk("hold_mask", 128'(cur.mask), 128'(p_w.mask));
      end
      if (wr_vld && wr_gnt) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got addr %h mask %h, want no request",
                   cur.addr, cur.mask);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 128'(cur.addr), 128'(e.addr));
          chk("wr_mask", 128'(cur.mask), 128'(e.mask));
          chk("wr_data", cur.data, e.data);
        end
        log_q.push_back(cur);
        logc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_all_written", 128'(exp_q.size()), 128'(0));
      end
      p_hold = wr_vld && !wr_gnt;
      p_w    = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [11:0] sa, input logic [3:0] rl,
                            input logic [3:0] cl, input logic [7:0] seed);
    int t;
    t = 0;
    while (!ctrl_rdy && t < 50) begin
      tick();
      t++;
    end
    chk("ctrl_rdy_before_start", 128'(ctrl_rdy), 128'(1));
    log_q.delete();
    logc_q.delete();
    build_expected(int'(sa), int'(rl), int'(cl), seed);
    ctrl_vld     = 1'b1;
    ctrl_row_len = rl;
    ctrl_col_len = cl;
    ctrl_start   = sa;
    tick();
    ctrl_vld = 1'b0;
  endtask

  task automatic send_rows(input int n, input logic [7:0] seed, output int c0);
    c0 = cyc;
    for (int r = 0; r < n; r++) begin
      res_vld  = 1'b1;
      res_data = row_pat(seed, r);
      tick();
    end
    res_vld  = 1'b0;
    res_data = '0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int t;
    d0 = done_cnt;
    t  = 0;
    while (done_cnt == d0 && t < budget) begin
      tick();
      t++;
    end
    chk("done_seen", 128'(done_cnt - d0), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    int cg;
    rst = 1'b1; ctrl_vld = 1'b0; ctrl_row_len = '0; ctrl_col_len = '0;
    ctrl_start = '0; res_vld = 1'b0; res_data = '0; wr_gnt = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_rdy",  128'(ctrl_rdy), 128'(1));
    chk("rst_vld",  128'(wr_vld),   128'(0));
    chk("rst_addr", 128'(wr_addr),  128'(0));
    chk("rst_data", wr_data,        128'(0));
    chk("rst_mask", 128'(wr_mask),  128'(0));
    chk("rst_done", 128'(done),     128'(0));
    rst = 1'b0;
    tick();

    // Aligned tile, grant always high
    start_tile(12'h120, 4'd3, 4'd15, 8'h10);
    chk("rdy_falls", 128'(ctrl_rdy), 128'(0));
    send_rows(4, 8'h10, c0);
    wait_done(60);
    chk("al_count", 128'(log_q.size()), 128'(4));
    chk("al_first_cyc", 128'(logc_q[0]), 128'(c0 + 1));
    chk("al_last_cyc", 128'(logc_q[3]), 128'(c0 + 4));
    chk("al_addr0", 128'(log_q[0].addr), 128'(8'h12));
    chk("al_addr3", 128'(log_q[3].addr), 128'(8'h15));
    chk("al_mask", 128'(log_q[2].mask), 128'(16'hFFFF));
    chk("al_done_cyc", 128'(done_cyc), 128'(logc_q[3] + 1));
    chk("rdy_after_done", 128'(ctrl_rdy), 128'(1));

    // Unaligned full width; extra row and a busy-time descriptor are ignored
    start_tile(12'h104, 4'd1, 4'd15, 8'h40);
    ctrl_vld = 1'b1; ctrl_row_len = 4'd15; ctrl_start = 12'h800;
    send_rows(3, 8'h40, c0);
    ctrl_vld = 1'b0;
    wait_done(60);
    chk("ua_count", 128'(log_q.size()), 128'(3));
    chk("ua_addr0", 128'(log_q[0].addr), 128'(8'h10));
    chk("ua_addr2", 128'(log_q[2].addr), 128'(8'h12));
    chk("ua_mask0", 128'(log_q[0].mask), 128'(16'hFFF0));
    chk("ua_mask1", 128'(log_q[1].mask), 128'(16'hFFFF));
    chk("ua_mask2", 128'(log_q[2].mask), 128'(16'h000F));
    chk("ua_data1", log_q[1].data, 128'h5B5A5958_57565554_53525150_4F4E4D4C);

    // Narrow tile whose tail line carries no bytes
    start_tile(12'h0FC, 4'd1, 4'd2, 8'h80);
    send_rows(2, 8'h80, c0);
    wait_done(60);
    repeat (5) tick();
    chk("sk_count", 128'(log_q.size()), 128'(2));
    chk("sk_addr0", 128'(log_q[0].addr), 128'(8'h0F));
    chk("sk_addr1", 128'(log_q[1].addr), 128'(8'h10));
    chk("sk_mask0", 128'(log_q[0].mask), 128'(16'h7000));
    chk("sk_mask1", 128'(log_q[1].mask), 128'(16'h7000));
    chk("sk_data0", log_q[0].data, {32'h00828180, 96'h0});

    // Backpressure: grant low for the first six cycles
    wr_gnt = 1'b0;
    start_tile(12'h120, 4'd3, 4'd15, 8'h20);
    send_rows(4, 8'h20, c0);
    tick();
    wr_gnt = 1'b1;
    cg = cyc;
    wait_done(60);
    chk("bp_count", 128'(log_q.size()), 128'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < log_q.size()) begin
        chk("bp_cyc", 128'(logc_q[k]), 128'(cg + k));
        chk("bp_addr", 128'(log_q[k].addr), 128'(8'h12 + 8'(k)));
      end
    end

    // Address wrap; a row offered while idle is ignored
    res_vld = 1'b1; res_data = {16{8'hEE}};
    tick();
    res_vld = 1'b0;
    start_tile(12'hFF0, 4'd1, 4'd15, 8'h30);
    send_rows(2, 8'h30, c0);
    wait_done(60);
    chk("wr_count", 128'(log_q.size()), 128'(2));
    chk("wr_addr0", 128'(log_q[0].addr), 128'(8'hFF));
    chk("wr_addr1", 128'(log_q[1].addr), 128'(8'h00));

    // Reset after two of four rows, then a fresh tile
    wr_gnt = 1'b0;
    start_tile(12'h200, 4'd3, 4'd15, 8'h50);
    send_rows(2, 8'h50, c0);
    chk("pre_rst_vld", 128'(wr_vld), 128'(1));
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    chk("post_rst_vld",  128'(wr_vld),   128'(0));
    chk("post_rst_rdy",  128'(ctrl_rdy), 128'(1));
    chk("post_rst_done", 128'(done),     128'(0));
    wr_gnt = 1'b1;
    start_tile(12'h300, 4'd3, 4'd15, 8'h60);
    send_rows(4, 8'h60, c0);
    wait_done(60);
    chk("rs_count", 128'(log_q.size()), 128'(4));
    chk("rs_addr0", 128'(log_q[0].addr), 128'(8'h30));

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
